// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter width, type and terminal-count helper
package counter_pkg;

   localparam int CNT_W = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic logic is_zero(input cnt_t value);
      return (value == '0);
   endfunction

endpackage

// File: rtl/down_count_4bit.sv
// rtl/down_count_4bit.sv - loadable free-running down counter with terminal-count flag
module down_count_4bit
   import counter_pkg::*;
#(
   parameter int               WIDTH     = CNT_W,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   // load has priority; otherwise decrement wraps naturally modulo 2^WIDTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= din;
      end else begin
         count <= count - 1'b1;
      end
   end

   generate
      if (WIDTH == CNT_W) begin : g_tc_pkg
         assign tc = is_zero(count);
      end else begin : g_tc_generic
         assign tc = (count == '0);
      end
   endgenerate

endmodule

// File: tb/tb_down_count_4bit.sv
// tb/tb_down_count_4bit.sv - directed vector bench for down_count_4bit
module tb_down_count_4bit;

   typedef struct {
      logic       load;
      logic [3:0] din;
      logic [3:0] exp_count;
      logic       exp_tc;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [3:0] din;
   logic       load;
   logic [3:0] count;
   logic       tc;

   int n_cmp;
   int n_bad;

   vec_t vecs[$];

   down_count_4bit dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .load  (load),
      .count (count),
      .tc    (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic add(input logic l, input logic [3:0] d, input logic [3:0] c, input logic t);
      vec_t v;
      v.load = l;
      v.din = d;
      v.exp_count = c;
      v.exp_tc = t;
      vecs.push_back(v);
   endtask

   task automatic edge_then_sample();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int tc_seen;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      load = 1'b0;
      din = 4'h0;

      // free-run from reset, then load 4 and wrap
      add(1'b0, 4'h0, 4'hF, 1'b0);
      add(1'b0, 4'h0, 4'hE, 1'b0);
      add(1'b0, 4'h0, 4'hD, 1'b0);
      add(1'b1, 4'h4, 4'h4, 1'b0);
      add(1'b0, 4'h0, 4'h3, 1'b0);
      add(1'b0, 4'h0, 4'h2, 1'b0);
      add(1'b0, 4'h0, 4'h1, 1'b0);
      add(1'b0, 4'h0, 4'h0, 1'b1);
      add(1'b0, 4'h0, 4'hF, 1'b0);
      add(1'b0, 4'h0, 4'hE, 1'b0);
      add(1'b0, 4'h0, 4'hD, 1'b0);
      add(1'b0, 4'h0, 4'hC, 1'b0);
      // load 10 while counting at 12
      add(1'b1, 4'hA, 4'hA, 1'b0);
      add(1'b0, 4'h0, 4'h9, 1'b0);
      add(1'b0, 4'h0, 4'h8, 1'b0);
      add(1'b0, 4'h0, 4'h7, 1'b0);
      add(1'b0, 4'h0, 4'h6, 1'b0);
      add(1'b0, 4'h0, 4'h5, 1'b0);
      // load held for three edges
      add(1'b1, 4'h7, 4'h7, 1'b0);
      add(1'b1, 4'h7, 4'h7, 1'b0);
      add(1'b1, 4'h7, 4'h7, 1'b0);
      add(1'b0, 4'h0, 4'h6, 1'b0);
      // load zero
      add(1'b1, 4'h0, 4'h0, 1'b1);
      add(1'b0, 4'h0, 4'hF, 1'b0);

      // asynchronous reset with clock not yet at an edge
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_count", 32'(count), 32'h0);
      check("async_reset_tc", 32'(tc), 32'h1);

      @(negedge clk);
      load = 1'b1;
      din = 4'h5;
      edge_then_sample();
      check("load_during_reset", 32'(count), 32'h0);
      rst = 1'b1;
      load = 1'b0;
      din = 4'h0;

      foreach (vecs[i]) begin
         load = vecs[i].load;
         din = vecs[i].din;
         edge_then_sample();
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
      end

      // reset mid-operation: load 9, reset between edges, load edge ignored
      load = 1'b1;
      din = 4'h9;
      edge_then_sample();
      check("mid_load9", 32'(count), 32'h9);
      load = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("mid_async_count", 32'(count), 32'h0);
      check("mid_async_tc", 32'(tc), 32'h1);
      load = 1'b1;
      din = 4'h3;
      edge_then_sample();
      check("mid_load_ignored", 32'(count), 32'h0);
      rst = 1'b1;
      edge_then_sample();
      check("post_release_load3", 32'(count), 32'h3);
      load = 1'b0;
      edge_then_sample();
      check("post_release_dec", 32'(count), 32'h2);

      // one full wrap free-running: tc high exactly once, back to start value
      tc_seen = 0;
      for (int k = 0; k < 16; k++) begin
         edge_then_sample();
         if (tc) tc_seen++;
      end
      check("wrap_tc_once", 32'(tc_seen), 32'd1);
      check("wrap_full_cycle", 32'(count), 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
